// File: rtl/intcalc_seq_pkg.sv
// Shared types for the iterative multiply/divide sequencer: operation codes and FSM states.
package intcalc_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL   = 3'd0,
    MD_MULH  = 3'd1,
    MD_MULHU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MOD   = 3'd5,
    MD_MODU  = 3'd6,
    MD_RSVD  = 3'd7
  } mdfunc_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdstate_t;

endpackage

// File: rtl/intcalc_seq_md_step.sv
// One iteration of the md datapath: shift/add multiply step or restoring-divide step.
// Divide packs {remainder, quotient} into i_acc; divisor sits in i_x[WIDTH-1:0].
module md_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_mul,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0]   i_y,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_x,
  output logic [WIDTH-1:0]   o_y
);

  logic [WIDTH:0] w_trial;

  always_comb begin
    w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_x[WIDTH-1:0]};
    o_acc   = i_acc;
    o_x     = i_x;
    o_y     = i_y;
    if (i_mul) begin
      o_acc = i_acc + (i_y[0] ? i_x : '0);
      o_x   = i_x << 1;
      o_y   = i_y >> 1;
    end else if (!w_trial[WIDTH]) begin
      // remainder < divisor keeps the trial difference within WIDTH bits when it does not borrow
      o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/intcalc_seq.sv
// Iterative multiply/divide sequencer with start/done handshake for the execute stage.
// Optional MD_EARLY_OUT_EN: multiplies leave RUN as soon as the remaining multiplier is zero.
module intcalc_seq
  import intcalc_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div0_o
);

  mdstate_t           r_state, w_state_nxt;
  mdfunc_t            r_func;
  logic [WIDTH-1:0]   r_a, r_b, r_y, r_result;
  logic [2*WIDTH-1:0] r_acc, r_x;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg, r_div0;

  logic               w_idle, w_accept, w_is_mul, w_is_signed, w_div0;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_pre_res, w_fix_res, w_done_res;
  logic [2*WIDTH-1:0] w_prod, w_acc_nxt, w_x_nxt;
  logic [WIDTH-1:0]   w_y_nxt;

  assign w_idle      = (r_state == IDLE) || (r_state == DONE);
  assign w_accept    = start_i && !flush_i && w_idle;
  assign w_is_mul    = (r_func == MD_MUL) || (r_func == MD_MULH) || (r_func == MD_MULHU);
  assign w_is_signed = (r_func == MD_MUL) || (r_func == MD_MULH) ||
                       (r_func == MD_DIV) || (r_func == MD_MOD);
  assign w_div0      = !w_is_mul && (r_func != MD_RSVD) && (r_b == '0);
  assign w_abs_a     = (w_is_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_abs_b     = (w_is_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_mul (w_is_mul),
    .i_acc (r_acc),
    .i_x   (r_x),
    .i_y   (r_y),
    .o_acc (w_acc_nxt),
    .o_x   (w_x_nxt),
    .o_y   (w_y_nxt)
  );

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quot = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_res = '0;
    w_pre_res = '0;
    case (r_func)
      MD_MUL:               w_fix_res = w_prod[WIDTH-1:0];
      MD_MULH, MD_MULHU:    w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:      begin w_fix_res = w_quot; w_pre_res = '1;  end
      MD_MOD, MD_MODU:      begin w_fix_res = w_rem;  w_pre_res = r_a; end
      default:              ;
    endcase
    w_done_res = (r_state == PREP) ? w_pre_res : w_fix_res;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: w_state_nxt = start_i ? PREP : IDLE;
      PREP:       w_state_nxt = (w_div0 || r_func == MD_RSVD) ? DONE : RUN;
      RUN: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
`ifdef MD_EARLY_OUT_EN
        else if (w_is_mul && w_y_nxt == '0) w_state_nxt = FIX;
`endif
      end
      FIX:        w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  always_comb begin
    busy_o  = (r_state == PREP) || (r_state == RUN) || (r_state == FIX);
    done_o  = (r_state == DONE);
    stall_o = (start_i && w_idle) || busy_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_func   <= MD_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (w_accept) begin
          r_func <= mdfunc_t'(func_i);
          r_a    <= a_i;
          r_b    <= b_i;
        end
        PREP: begin
          r_neg <= (r_func == MD_MOD) ? r_a[WIDTH-1] :
                   (w_is_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]));
          r_cnt <= CNT_W'(WIDTH);
          if (w_is_mul) begin
            r_acc <= '0;
            r_x   <= {{WIDTH{1'b0}}, w_abs_a};
            r_y   <= w_abs_b;
          end else begin
            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
            r_x   <= {{WIDTH{1'b0}}, w_abs_b};
            r_y   <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
      // a flush forces IDLE, so an aborted op never overwrites the held result
      if (w_state_nxt == DONE && r_state != DONE) begin
        r_result <= w_done_res;
        r_div0   <= (r_state == PREP) && w_div0;
      end
    end
  end

  assign result_o = r_result;
  assign div0_o   = r_div0;

endmodule

// File: doc/intcalc_seq.md
Name: intcalc_seq

Overview:
Iterative multiply/divide sequencer for the execute stage. It replaces the fixed 4-cycle intcalc delay counter with a real multi-cycle unit that has a start/done handshake. Execute issues one T_INT/T_INTU operation, holds the pipeline on stall_o, and captures result_o when done_o is high. The unit handles one operation at a time and is shared by signed and unsigned operations.

Parameters:
WIDTH, 32, operand/result width; all widths below assume 32.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  request; sampled only in IDLE or DONE
func_i  input  3  mdfunc_t operation code
a_i  input  32  operand 1 (multiplicand / dividend)
b_i  input  32  operand 2 (multiplier / divisor)
flush_i  input  1  synchronous abort (exception or pipeline flush)
busy_o  output  1  high in PREP, RUN, FIX
stall_o  output  1  start_i accepted this cycle, or busy_o
done_o  output  1  one-cycle pulse; result_o valid
result_o  output  32  result; held until the next accepted start
div0_o  output  1  divide-by-zero flag; valid with done_o, held like result_o

Behaviour:
- Reset: state=IDLE; busy_o=0, done_o=0, div0_o=0, result_o=0, counter=0, internal registers=0.
- func encoding: 0 MUL (low 32 bits), 1 MULH (signed high), 2 MULHU (unsigned high), 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved.
- States:
  - IDLE/DONE -> PREP on start_i && !flush_i. Operands and func are latched at that edge. Call this edge cycle 0.
  - PREP (cycle 1):
    - Signed ops take absolute values and record the result sign. For DIV/MULH it is sign(a)^sign(b); for MOD it is sign(a).
    - Divide by zero (b==0, func 3-6) goes directly to DONE with div0_o=1. Quotient result = 0xFFFFFFFF; remainder result = a_i unmodified.
    - func 7 goes to DONE with result 0.
    - All other cases go to RUN with counter = WIDTH.
  - RUN (cycles 2..33): one bit per cycle.
    - Multiply: 64-bit accumulator. Multiplicand shifts left and multiplier shifts right; add when the multiplier LSB is 1.
    - Divide: restoring divide, one quotient bit per cycle from the MSB.
    - Counter decrements each cycle; RUN -> FIX when counter reaches 1.
  - FIX (cycle 34): apply two's-complement negation if the recorded sign is set, then select the result word. -> DONE.
  - DONE (cycle 35): done_o=1 for exactly one cycle; result_o/div0_o registered. Next cycle -> IDLE unless a new start is accepted.
- Latency: 35 cycles start-to-done for normal ops; 2 cycles for div-by-zero and func 7.
- stall_o is combinational: (start_i && state in {IDLE, DONE}) || busy_o. It is low in the DONE cycle, so execute advances and captures result_o.
- Back-to-back: start_i in the DONE cycle is accepted; done_o still pulses that cycle.
- start_i while busy is ignored. The issuer must hold start_i until stall_o drops.
- flush_i in any state:
  - Next state IDLE, no done_o, result_o unchanged.
  - flush_i together with start_i: flush wins, start is dropped.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, MOD result 0. No trap.
- Reset mid-operation aborts immediately; outputs return to reset values.

Optional Feature:
MD_EARLY_OUT_EN:
- Defined: multiply ops (func 0-2) leave RUN -> FIX once the remaining multiplier register is zero, after at least one RUN cycle. Done cycle = n+3, where n = max(1, bit length of |b|). Division is unaffected.
- Undefined: fixed 32 RUN cycles for all ops. No early-out logic is synthesized.

Decomposition:
- bexkat1Def gains the mdfunc_t enum (MD_MUL..MD_RSVD) and the mdstate_t enum (IDLE, PREP, RUN, FIX, DONE).
- One sub-module, md_step: combinational single-iteration shift/add and shift/subtract datapath, selected by a mul/div flag.
- The FSM, counter and sign handling stay in intcalc_seq.

Test Plan:
- MUL a=7, b=6 -> stall_o high cycles 0-34; done_o at cycle 35 only; result_o=0x0000002A, div0_o=0. With MD_EARLY_OUT_EN: done at cycle 6.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD. MOD same operands -> 0xFFFFFFFF. MODU same operands -> 0x00000001.
- DIVU a=5, b=0 -> done_o at cycle 2, result 0xFFFFFFFF, div0_o=1. MODU a=5, b=0 -> result 5, div0_o=1.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- flush_i at cycle 10 of a DIV -> busy_o low at cycle 11, no done_o, result_o keeps its previous value. A new MUL 3*5 then completes with result 15.
- start_i held high during the DONE cycle of MUL 2*3 -> done_o with result 6, then a second op (DIVU 9/3) is accepted and done_o with result 3 occurs 35 cycles later. start_i asserted with flush_i -> not accepted.
